// File: rtl/fifo_pkt_framer.sv
// Read-side consumer of the camera async FIFO: frames drained bytes into
// sync/seq/len/payload/checksum packets, with backpressure and stall padding.
module fifo_pkt_framer #(
  parameter int unsigned PKT_LEN = 10,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 11,
  parameter logic [7:0]  SYNC0   = 8'hA5,
  parameter logic [7:0]  SYNC1   = 8'h5A
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_valid,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        pkt_done,
  output logic        pad_err,
  output logic [15:0] seq_num
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_CSUM} state_t;

  localparam logic [15:0]      LP_LEN16  = 16'(PKT_LEN);
  localparam logic [LEN_W-1:0] LP_LEN    = LEN_W'(PKT_LEN);
  localparam logic [LEN_W-1:0] LP_LEN_M1 = LEN_W'(PKT_LEN - 1);
  localparam logic [TO_W-1:0]  LP_TO_M1  = TO_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_hdr_idx;
  logic [LEN_W-1:0] r_pay_cnt;
  logic [LEN_W-1:0] r_rd_cnt;
  logic             r_inflight;
  logic [7:0]       r_skid [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_occ;
  logic [7:0]       r_csum;
  logic [15:0]      r_seq;
  logic [TO_W-1:0]  r_to;
  logic             r_padding;
  logic             r_pkt_done;
  logic             r_pad_err;

  logic [7:0]       w_hdr_byte;
  logic [7:0]       w_m_data;
  logic             w_m_valid;
  logic             w_m_last;
  logic             w_xfer;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_slots;
  logic             w_rd_en;
  logic             w_to_run;
  logic             w_pad_start;

  always_comb begin
    w_hdr_byte = 8'h00;
    case (r_hdr_idx)
      3'd0:    w_hdr_byte = SYNC0;
      3'd1:    w_hdr_byte = SYNC1;
      3'd2:    w_hdr_byte = r_seq[15:8];
      3'd3:    w_hdr_byte = r_seq[7:0];
      3'd4:    w_hdr_byte = LP_LEN16[15:8];
      3'd5:    w_hdr_byte = LP_LEN16[7:0];
      default: w_hdr_byte = 8'h00;
    endcase
  end

  // Next state and output byte; the payload source is the skid head, or zero once padding.
  always_comb begin
    w_state_nxt = r_state;
    w_m_valid   = 1'b0;
    w_m_data    = 8'h00;
    w_m_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && !fifo_empty) w_state_nxt = S_HDR;
      end
      S_HDR: begin
        w_m_valid = 1'b1;
        w_m_data  = w_hdr_byte;
        if (m_ready && (r_hdr_idx == 3'd5)) w_state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_m_valid = (r_occ != 2'd0) || r_padding;
        w_m_data  = r_padding ? 8'h00 : r_skid[r_rptr];
        if (w_m_valid && m_ready && (r_pay_cnt == LP_LEN_M1)) w_state_nxt = S_CSUM;
      end
      S_CSUM: begin
        w_m_valid = 1'b1;
        w_m_data  = r_csum;
        w_m_last  = 1'b1;
        if (m_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pushes only count when a read of ours is outstanding, so stale data after reset is dropped.
  assign w_xfer      = w_m_valid && m_ready;
  assign w_push      = fifo_valid && r_inflight;
  assign w_pop       = (r_state == S_PAYLOAD) && w_xfer && !r_padding;
  assign w_slots     = r_occ + {1'b0, r_inflight};
  assign w_rd_en     = (r_state == S_PAYLOAD) && !fifo_empty && (r_rd_cnt < LP_LEN) &&
                       (w_slots < 2'd2) && !r_padding;
  assign w_to_run    = (r_state == S_PAYLOAD) && (r_occ == 2'd0) && !r_inflight &&
                       fifo_empty && !r_padding;
  assign w_pad_start = w_to_run && !w_push && (r_to == LP_TO_M1);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hdr_idx  <= 3'd0;
      r_pay_cnt  <= '0;
      r_rd_cnt   <= '0;
      r_inflight <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_occ      <= 2'd0;
      r_csum     <= 8'h00;
      r_seq      <= 16'h0000;
      r_to       <= '0;
      r_padding  <= 1'b0;
      r_pkt_done <= 1'b0;
      r_pad_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pkt_done <= (r_state == S_CSUM) && w_xfer;
      r_pad_err  <= w_pad_start;
      r_inflight <= w_rd_en;

      if (r_state == S_IDLE)                r_hdr_idx <= 3'd0;
      else if ((r_state == S_HDR) && w_xfer) r_hdr_idx <= r_hdr_idx + 3'd1;

      if (r_state != S_PAYLOAD) begin
        r_pay_cnt <= '0;
        r_rd_cnt  <= '0;
      end else begin
        if (w_xfer)  r_pay_cnt <= r_pay_cnt + 1'b1;
        if (w_rd_en) r_rd_cnt  <= r_rd_cnt + 1'b1;
      end

      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase

      if (r_state == S_IDLE)                     r_csum <= 8'h00;
      else if ((r_state == S_PAYLOAD) && w_xfer) r_csum <= r_csum + w_m_data;

      if ((r_state == S_CSUM) && w_xfer) r_seq <= r_seq + 16'd1;

      if ((r_state != S_PAYLOAD) || w_push) r_to <= '0;
      else if (w_to_run)                    r_to <= (r_to == LP_TO_M1) ? '0 : r_to + 1'b1;

      if (r_state == S_IDLE) r_padding <= 1'b0;
      else if (w_pad_start)  r_padding <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) r_skid[r_wptr] <= fifo_dout;
  end

  assign fifo_rd_en = w_rd_en;
  assign m_data     = w_m_data;
  assign m_valid    = w_m_valid;
  assign m_last     = w_m_last;
  assign pkt_done   = r_pkt_done;
  assign pad_err    = r_pad_err;
  assign seq_num    = r_seq;

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Directed bench for fifo_pkt_framer with a 1-cycle-latency FIFO model and an output byte monitor.
module tb_fifo_pkt_framer;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_valid = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        pkt_done;
  logic        pad_err;
  logic [15:0] seq_num;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] fifo_q [$];
  int         rd_acc = 0;
  logic       rdy_rand = 1'b0;

  logic [7:0] cap_d [$];
  logic       cap_l [$];
  int         cap_base = 0;
  int         n_done = 0;
  int         n_pad = 0;
  int         pad_gap = -1;
  int         hold_bad = 0;
  int         idle_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  fifo_pkt_framer #(
    .PKT_LEN(4), .LEN_W(16), .TIMEOUT(16), .TO_W(5), .SYNC0(8'hA5), .SYNC1(8'h5A)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_valid(fifo_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .pkt_done(pkt_done), .pad_err(pad_err), .seq_num(seq_num)
  );

  always #5 sys_clk = ~sys_clk;

  // FIFO read side: data and valid appear one cycle after an accepted read.
  always @(posedge sys_clk) begin
    fifo_valid <= 1'b0;
    if (fifo_rd_en && (fifo_q.size() > 0)) begin
      fifo_dout  <= fifo_q.pop_front();
      fifo_valid <= 1'b1;
      rd_acc     <= rd_acc + 1;
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(posedge sys_clk) begin
    #1;
    m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge sys_clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid || (m_data != prev_data) || (m_last != prev_last)))
        hold_bad = hold_bad + 1;
      if (m_valid && m_ready) begin
        cap_d.push_back(m_data);
        cap_l.push_back(m_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (pkt_done) n_done = n_done + 1;
      if (pad_err) begin
        n_pad   = n_pad + 1;
        pad_gap = idle_cnt;
      end
      if (fifo_valid)    idle_cnt = 0;
      else if (!m_valid) idle_cnt = idle_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int k;
    k = 0;
    while (((cap_d.size() - cap_base) < n) && (k < 500)) begin
      step(1);
      k++;
    end
    chk({tag, "_cnt"}, 32'(cap_d.size() - cap_base), 32'(n));
  endtask

  task automatic chk_frame(input logic [7:0] e [0:10], input string tag);
    logic [10:0] lst;
    wait_bytes(11, tag);
    lst = '0;
    for (int i = 0; i < 11; i++) begin
      if ((cap_base + i) < cap_d.size()) begin
        chk($sformatf("%s_b%0d", tag, i), 32'(cap_d[cap_base + i]), 32'(e[i]));
        lst[i] = cap_l[cap_base + i];
      end else begin
        chk($sformatf("%s_b%0d", tag, i), 32'hFFFF_FFFF, 32'(e[i]));
      end
    end
    chk({tag, "_last"}, 32'(lst), 32'h400);
    cap_base = cap_base + 11;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk(tag, {15'd0, fifo_rd_en, m_valid, m_last, pkt_done, pad_err, m_data, seq_num[3:0]}, 32'h0);
    chk({tag, "_seq"}, 32'(seq_num), 32'h0);
  endtask

  initial begin
    logic [7:0] e [0:10];
    int b_rd, b_done, b_pad, k, nl;

    rst_n  = 1'b0;
    enable = 1'b0;
    step(3);
    chk_idle_outs("reset");
    rst_n = 1'b1;
    step(2);

    // T1: clean packet, ready always high
    b_rd = rd_acc; b_done = n_done;
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h02);
    fifo_q.push_back(8'h03); fifo_q.push_back(8'h04);
    step(2);
    enable = 1'b1;
    e = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    chk_frame(e, "t1");
    step(3);
    chk("t1_done", 32'(n_done - b_done), 32'd1);
    chk("t1_seq", 32'(seq_num), 32'd1);
    chk("t1_rd", 32'(rd_acc - b_rd), 32'd4);

    // T2: same data under random backpressure
    rdy_rand = 1'b1;
    b_rd = rd_acc; b_done = n_done;
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h02);
    fifo_q.push_back(8'h03); fifo_q.push_back(8'h04);
    e = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    chk_frame(e, "t2");
    step(3);
    rdy_rand = 1'b0;
    step(2);
    chk("t2_hold", 32'(hold_bad), 32'd0);
    chk("t2_done", 32'(n_done - b_done), 32'd1);
    chk("t2_seq", 32'(seq_num), 32'd2);
    chk("t2_rd", 32'(rd_acc - b_rd), 32'd4);

    // T3: stream stalls after two bytes; a byte arriving during padding must not be read
    b_rd = rd_acc; b_pad = n_pad;
    fifo_q.push_back(8'h05); fifo_q.push_back(8'h06);
    k = 0;
    while ((n_pad == b_pad) && (k < 200)) begin
      step(1);
      k++;
    end
    enable = 1'b0;
    fifo_q.push_back(8'h77);
    e = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h00, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00, 8'h0B};
    chk_frame(e, "t3");
    step(3);
    chk("t3_pad", 32'(n_pad - b_pad), 32'd1);
    chk("t3_gap", 32'(pad_gap), 32'd16);
    chk("t3_rd", 32'(rd_acc - b_rd), 32'd2);
    chk("t3_seq", 32'(seq_num), 32'd3);

    // T4: sequence number wrap
    force dut.r_seq = 16'hFFFF;
    step(1);
    release dut.r_seq;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    step(2);
    enable = 1'b1;
    e = '{8'hA5, 8'h5A, 8'hFF, 8'hFF, 8'h00, 8'h04, 8'h77, 8'h11, 8'h22, 8'h33, 8'hDD};
    chk_frame(e, "t4");
    step(3);
    chk("t4_seq", 32'(seq_num), 32'd0);

    // T5: enable dropped mid-payload with more data waiting
    fifo_q.push_back(8'h10); fifo_q.push_back(8'h20); fifo_q.push_back(8'h30); fifo_q.push_back(8'h40);
    fifo_q.push_back(8'h50); fifo_q.push_back(8'h60); fifo_q.push_back(8'h70); fifo_q.push_back(8'h80);
    wait_bytes(8, "t5_mid");
    enable = 1'b0;
    e = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
    chk_frame(e, "t5");
    step(30);
    chk("t5_nohdr", 32'(cap_d.size() - cap_base), 32'd0);
    chk("t5_valid", 32'(m_valid), 32'd0);
    chk("t5_seq", 32'(seq_num), 32'd1);

    // T6: reset while a payload read is in flight
    enable = 1'b1;
    k = 0;
    while (!fifo_rd_en && (k < 200)) begin
      step(1);
      k++;
    end
    chk("t6_rd_seen", 32'(fifo_rd_en), 32'd1);
    @(posedge sys_clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_outs("t6_rst");
    nl = 0;
    for (int i = cap_base; i < cap_d.size(); i++) nl = nl + int'(cap_l[i]);
    chk("t6_nolast", 32'(nl), 32'd0);
    step(2);
    rst_n = 1'b1;
    cap_base = cap_d.size();
    fifo_q.push_back(8'h90);
    e = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h04, 8'h60, 8'h70, 8'h80, 8'h90, 8'hE0};
    chk_frame(e, "t6");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
